// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage fed by the EX-stage ALU.
//   - Pass-through instructions are registered to writeback with 1-cycle latency.
//   - Aligned loads/stores run a mem_req/mem_ack handshake. in_ready stays low
//     while the access is outstanding.
//   - Misaligned accesses and accesses that reach TIMEOUT cycles without mem_ack
//     complete immediately with an error pulse. Their load data is 0.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   in_*            EX-side instruction bundle and valid; in_ready = stage idle
//   mem_*           data-memory request/acknowledge interface
//   out_*           writeback bundle; out_valid is a one-cycle pulse
//   err_misalign    one-cycle pulse with out_valid (misaligned load/store)
//   err_timeout     one-cycle pulse with out_valid (memory never acknowledged)
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned RD_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_aluResult,
  input  logic [31:0]     in_op2,
  input  logic            in_isLd,
  input  logic            in_isSt,
  input  logic            in_isWb,
  input  logic [RD_W-1:0] in_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic            out_valid,
  output logic [31:0]     out_aluResult,
  output logic [31:0]     out_ldResult,
  output logic [RD_W-1:0] out_rd,
  output logic            out_isWb,
  output logic            out_isLd,
  output logic            err_misalign,
  output logic            err_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [RD_W-1:0] rd_q;
  logic            wb_q, ld_q;
  logic            accept, is_mem, aligned, last_cycle;

  always_comb begin
    in_ready   = (state == IDLE);
    mem_req    = (state == BUSY);
    accept     = in_valid & in_ready;
    is_mem     = in_isLd | in_isSt;
    aligned    = (in_aluResult[1:0] == 2'b00);
    last_cycle = (cnt == CW'(TIMEOUT - 1));
    state_next = state;
    unique case (state)
      IDLE: if (accept && is_mem && aligned) state_next = BUSY;
      BUSY: if (mem_ack || last_cycle)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The writeback bundle of a memory access is staged in mem_addr/rd_q/wb_q/ld_q
  // and copied to the outputs at completion, so outputs hold between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      rd_q          <= '0;
      wb_q          <= 1'b0;
      ld_q          <= 1'b0;
      out_valid     <= 1'b0;
      out_aluResult <= '0;
      out_ldResult  <= '0;
      out_rd        <= '0;
      out_isWb      <= 1'b0;
      out_isLd      <= 1'b0;
      err_misalign  <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state        <= state_next;
      out_valid    <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (is_mem && aligned) begin
              mem_addr  <= in_aluResult;
              mem_wdata <= in_op2;
              // Load+store together is treated as a load.
              mem_we    <= in_isSt & ~in_isLd;
              rd_q      <= in_rd;
              wb_q      <= in_isWb;
              ld_q      <= in_isLd;
              cnt       <= '0;
            end else begin
              out_valid     <= 1'b1;
              out_aluResult <= in_aluResult;
              out_ldResult  <= '0;
              out_rd        <= in_rd;
              out_isWb      <= in_isWb;
              out_isLd      <= in_isLd;
              err_misalign  <= is_mem;
            end
          end
        end
        BUSY: begin
          if (mem_ack || last_cycle) begin
            // An ack on the final cycle wins over the timeout.
            out_valid     <= 1'b1;
            out_aluResult <= mem_addr;
            out_ldResult  <= (mem_ack && !mem_we) ? mem_rdata : '0;
            out_rd        <= rd_q;
            out_isWb      <= wb_q;
            out_isLd      <= ld_q;
            err_timeout   <= ~mem_ack;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int T    = 4;
  localparam int RD_W = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready;
  logic [31:0]     in_aluResult, in_op2;
  logic            in_isLd, in_isSt, in_isWb;
  logic [RD_W-1:0] in_rd;
  logic            mem_req, mem_we, mem_ack;
  logic [31:0]     mem_addr, mem_wdata, mem_rdata;
  logic            out_valid, out_isWb, out_isLd, err_misalign, err_timeout;
  logic [31:0]     out_aluResult, out_ldResult;
  logic [RD_W-1:0] out_rd;

  int errors = 0;
  int checks = 0;
  logic        have_prev = 1'b0;
  logic [31:0] prev_alu  = '0;

  mem_access_stage #(.TIMEOUT(T), .RD_W(RD_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluResult(in_aluResult), .in_op2(in_op2),
    .in_isLd(in_isLd), .in_isSt(in_isSt), .in_isWb(in_isWb), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_aluResult(out_aluResult), .out_ldResult(out_ldResult),
    .out_rd(out_rd), .out_isWb(out_isWb), .out_isLd(out_isLd),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          reqs;
    logic [31:0] ld;
    logic        mis;
    logic        to;
  } exp_t;

  // Transaction-level reference: ack_at = mem_req cycle carrying mem_ack
  // (values above T mean the memory never answers).
  function automatic exp_t model(input logic [31:0] a, input logic ld, input logic st,
                                 input int ack_at, input logic [31:0] rdata);
    exp_t e;
    e.lat = 1; e.reqs = 0; e.ld = 32'h0; e.mis = 1'b0; e.to = 1'b0;
    if (ld || st) begin
      if (a % 4 != 0) e.mis = 1'b1;
      else if (ack_at <= T) begin
        e.reqs = ack_at;
        e.lat  = ack_at + 1;
        e.ld   = ld ? rdata : 32'h0;
      end else begin
        e.reqs = T;
        e.lat  = T + 1;
        e.to   = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_instr(input logic [31:0] a, input logic [31:0] op2,
                           input logic ld, input logic st, input logic wb,
                           input logic [RD_W-1:0] rd, input int ack_at,
                           input logic [31:0] rdata);
    exp_t e;
    int   n, reqc;
    logic done;
    e = model(a, ld, st, ack_at, rdata);
    @(negedge clk);
    if (have_prev) begin
      chk("pulse_low", {29'b0, out_valid, err_misalign, err_timeout}, 32'h0);
      chk("hold_alu", out_aluResult, prev_alu);
    end
    chk("ready_idle", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b1; in_aluResult = a; in_op2 = op2;
    in_isLd = ld; in_isSt = st; in_isWb = wb; in_rd = rd;
    mem_ack = 1'($urandom % 2);   // must be ignored: no request outstanding
    mem_rdata = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0; in_aluResult = $urandom; in_op2 = $urandom;
    in_isLd = 1'($urandom % 2); in_isSt = 1'($urandom % 2); in_rd = RD_W'($urandom);
    n = 0; reqc = 0; done = 1'b0;
    while (!done && n < T + 6) begin
      @(negedge clk);
      n++;
      if (out_valid) done = 1'b1;
      else if (mem_req) begin
        reqc++;
        chk("mem_addr", mem_addr, a);
        chk("mem_wdata", mem_wdata, op2);
        chk("mem_we", {31'b0, mem_we}, {31'b0, st & ~ld});
        chk("ready_busy", {31'b0, in_ready}, 32'h0);
        mem_ack   = (reqc == ack_at);
        mem_rdata = (reqc == ack_at) ? rdata : $urandom;
      end else mem_ack = 1'b0;
    end
    mem_ack = 1'b0;
    chk("completed", {31'b0, done}, 32'h1);
    chk("latency", n, e.lat);
    chk("req_cycles", reqc, e.reqs);
    chk("out_alu", out_aluResult, a);
    chk("out_ld", out_ldResult, e.ld);
    chk("out_rd", {28'b0, out_rd}, {28'b0, rd});
    chk("out_flags", {30'b0, out_isWb, out_isLd}, {30'b0, wb, ld});
    chk("err_misalign", {31'b0, err_misalign}, {31'b0, e.mis});
    chk("err_timeout", {31'b0, err_timeout}, {31'b0, e.to});
    have_prev = 1'b1;
    prev_alu  = a;
  endtask

  initial begin
    logic [31:0] pt [3];
    logic [31:0] a;
    int          kind;
    reset = 1'b1; in_valid = 1'b0; in_aluResult = '0; in_op2 = '0;
    in_isLd = 1'b0; in_isSt = 1'b0; in_isWb = 1'b0; in_rd = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_ctrl", {26'b0, mem_req, mem_we, out_valid, err_misalign, err_timeout, out_isWb}, 32'h0);
    chk("rst_alu", out_aluResult, 32'h0);
    chk("rst_ld", out_ldResult, 32'h0);

    // Back-to-back pass-throughs, one per cycle.
    pt[0] = 32'h10; pt[1] = 32'h20; pt[2] = 32'h30;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_aluResult = pt[i]; in_isWb = 1'b1; in_rd = RD_W'(i + 1);
      @(negedge clk);
      chk("b2b_valid", {31'b0, out_valid}, 32'h1);
      chk("b2b_alu", out_aluResult, pt[i]);
      chk("b2b_ld", out_ldResult, 32'h0);
      chk("b2b_ready", {31'b0, in_ready}, 32'h1);
    end
    in_valid = 1'b0;
    have_prev = 1'b1; prev_alu = 32'h30;

    run_instr(32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 4'h3, 3, 32'hCAFEBABE);
    run_instr(32'h40, 32'h12345678, 1'b0, 1'b1, 1'b0, 4'h0, 1, 32'hDEADBEEF);
    run_instr(32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 4'h5, 1, 32'h11111111);
    run_instr(32'h200, 32'h0, 1'b1, 1'b0, 1'b1, 4'h6, T + 1, 32'h22222222);
    run_instr(32'h204, 32'h0, 1'b1, 1'b0, 1'b1, 4'h7, T, 32'h33333333);
    run_instr(32'h208, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b1, 4'h8, 2, 32'h44444444);

    // Reset in the 2nd BUSY cycle discards the in-flight load.
    @(negedge clk);
    in_valid = 1'b1; in_aluResult = 32'h300; in_isLd = 1'b1; in_isSt = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk("rst_busy_req", {31'b0, mem_req}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mid_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_mid_ready", {31'b0, in_ready}, 32'h1);
    prev_alu = 32'h0;
    run_instr(32'h55, 32'h0, 1'b0, 1'b0, 1'b1, 4'h9, 1, 32'h0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom % 4 != 0) a[1:0] = 2'b00;
      kind = int'($urandom % 4);
      run_instr(a, $urandom, kind[0], kind[1], 1'($urandom % 2), RD_W'($urandom),
                int'($urandom_range(1, T + 1)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access (MA) stage directly downstream of the execute-stage ALU. It takes the ALU result, the store operand and the load/store controls from the EX side.
- For loads and stores it runs a request/acknowledge transaction with data memory, holding off the EX stage while that transaction is outstanding.
- For all other instructions it registers the ALU result through to the register-writeback stage with one cycle of latency.
- It also detects misaligned addresses and memory timeouts.

Parameters:
- TIMEOUT, 64: maximum number of cycles mem_req stays high without mem_ack before the access is aborted. Must be at least 2.
- RD_W, 4: width of the destination register index.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  EX stage presents an instruction this cycle.
- in_ready  out  1  stage can accept an instruction. EX stalls while this is low.
- in_aluResult  in  32  ALU result; used as the address for loads and stores.
- in_op2  in  32  store data.
- in_isLd  in  1  instruction is a load.
- in_isSt  in  1  instruction is a store.
- in_isWb  in  1  instruction writes a register.
- in_rd  in  RD_W  destination register index.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  word-aligned byte address.
- mem_wdata  out  32  store data.
- mem_ack  in  1  memory completes the access. Sampled only while mem_req=1.
- mem_rdata  in  32  read data, valid in the mem_ack cycle.
- out_valid  out  1  one-cycle pulse: result bundle is valid for the writeback stage.
- out_aluResult  out  32  registered ALU result.
- out_ldResult  out  32  load data; 0 for non-loads, aborted loads and misaligned loads.
- out_rd  out  RD_W  registered in_rd.
- out_isWb  out  1  registered in_isWb.
- out_isLd  out  1  registered in_isLd.
- err_misalign  out  1  one-cycle pulse, concurrent with out_valid.
- err_timeout  out  1  one-cycle pulse, concurrent with out_valid.

Behaviour:
- Reset
  - When reset is high at a clock edge: state goes to IDLE, counter clears, and every output register clears to 0. in_ready is 1 on the cycle after reset.
  - Reset asserted mid-transaction drops mem_req after that edge; the in-flight instruction is discarded and no out_valid is produced.
- FSM states: IDLE and BUSY.
- in_ready = (state == IDLE). It is a combinational decode of the state register.
- Accept: an instruction is accepted at an edge where in_valid & in_ready.
- IDLE, accept, neither in_isLd nor in_isSt (pass-through)
  - Register the bundle; out_valid=1 on the next cycle; stay in IDLE. Latency is 1.
  - Back-to-back pass-throughs sustain one instruction per cycle.
- IDLE, accept, load or store with in_aluResult[1:0] != 0 (misaligned)
  - No memory request is made.
  - Next cycle: out_valid=1, err_misalign=1, out_ldResult=0.
- IDLE, accept, aligned load or store
  - Latch the address, data and kind, then go to BUSY.
  - In BUSY: mem_req=1; mem_addr, mem_wdata and mem_we are held constant.
  - mem_we = in_isSt & ~in_isLd. If in_isLd and in_isSt are both 1, the instruction is treated as a load.
- BUSY, mem_ack=1 at an edge
  - Capture mem_rdata into out_ldResult if the access is a load; capture 0 if it is a store.
  - out_valid=1 on the next cycle, mem_req=0, return to IDLE. A new instruction can be accepted on the following edge.
  - Load latency = 1 + number of cycles mem_req is high.
  - mem_ack in the very first BUSY cycle is legal, giving a latency of 2.
- BUSY, timeout
  - The counter clears on accept and increments at every BUSY edge without mem_ack.
  - If the counter == TIMEOUT-1 and mem_ack=0 at an edge: abort. mem_req=0 next cycle, out_valid=1, err_timeout=1, out_ldResult=0, return to IDLE.
  - mem_req is therefore high for exactly TIMEOUT cycles.
  - mem_ack arriving on that same edge wins: normal completion, no error.
- mem_ack while mem_req=0 is ignored.
- Output registers hold their values between out_valid pulses; only out_valid, err_misalign and err_timeout are pulses.
- The writeback stage always accepts; there is no output backpressure.

Test Plan:
- Reset, then pass-throughs: in_valid=1, in_isLd=0, in_isSt=0, in_aluResult 0x10, 0x20, 0x30 on three consecutive cycles -> out_valid high for three consecutive cycles carrying 0x10, 0x20, 0x30; out_ldResult=0; in_ready stays 1.
- Load, addr 0x100, memory acks 3 cycles after mem_req rises with mem_rdata=0xCAFEBABE -> mem_req high for 3 cycles with mem_we=0 and mem_addr=0x100; in_ready=0 throughout; out_valid one cycle after ack with out_ldResult=0xCAFEBABE and out_aluResult=0x100.
- Store, addr 0x40, in_op2=0x12345678, ack in the first BUSY cycle -> mem_we=1, mem_wdata=0x12345678, mem_req high for 1 cycle; out_valid 2 cycles after accept with out_ldResult=0.
- Misaligned load, addr 0x102 -> mem_req never rises; next cycle out_valid=1, err_misalign=1, out_ldResult=0.
- TIMEOUT=4, load with no ack -> mem_req high for exactly 4 cycles, then out_valid=1 and err_timeout=1. Rerun with ack in the 4th cycle -> normal completion, err_timeout=0.
- Reset asserted in the 2nd BUSY cycle -> mem_req=0 after that edge, no out_valid, in_ready=1 next cycle; a following pass-through completes normally.
